ids_lab05_scan_decoder: RTL

Parametrised, registered N-to-2^N decoder with enable. It generalises the lab 1-to-2 enable decoder in width, and adds an auto-scan mode that walks a one-hot output across all lines at a programmable rate. It is intended for multiplexed display digit/row selection in later lab designs. All outputs are registered to a single clock domain.

---
 rtl/ids_lab05_scan_decoder_if.sv | 15 +
 rtl/ids_lab05_scan_decoder.sv | 60 ++++++
 2 files changed

// File: rtl/ids_lab05_scan_decoder_if.sv
// ids_lab05_scan_decoder_if: control inputs and decoded outputs of the scan decoder
interface ids_lab05_scan_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUTS = 2 ** SEL_W;
  logic             e;
  logic             mode;
  logic [SEL_W-1:0] a;
  logic [OUTS-1:0]  d;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             wrap;
  modport master (output e, mode, a, input d, idx, valid, wrap);
  modport slave  (input e, mode, a, output d, idx, valid, wrap);
endinterface

// File: rtl/ids_lab05_scan_decoder.sv
// ids_lab05_scan_decoder: registered N-to-2^N decoder with enable and auto-scan mode.
// Define DEC_ACTIVE_LOW_EN to drive d inverted (active line low, idle all ones).
module ids_lab05_scan_decoder #(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 4,
  parameter int DIV_W    = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  ids_lab05_scan_decoder_if.slave bus
);
  localparam int OUTS = 2 ** SEL_W;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t           state_q, state_d;
  logic [OUTS-1:0]  d_q, d_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_q, valid_d, wrap_q, wrap_d, step;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  always_comb begin
    state_d = !bus.e ? IDLE : (bus.mode ? SCAN : DIRECT);
    step    = state_q == SCAN && div_q == DIV_W'(SCAN_DIV - 1);
    idx_d   = idx_q;
    div_d   = '0;
    wrap_d  = 1'b0;
    // Entering scan (from any other state) restarts at a with a fresh dwell
    if (state_d == DIRECT || (state_d == SCAN && state_q != SCAN))
      idx_d = bus.a;
    else if (state_d == SCAN) begin
      div_d  = step ? '0 : div_q + 1'b1;
      idx_d  = step ? idx_q + 1'b1 : idx_q;
      wrap_d = step && idx_q == SEL_W'(OUTS - 1);
    end
    d_d     = state_d == IDLE ? '0 : OUTS'(1) << idx_d;
    valid_d = state_d != IDLE;
  end
`ifdef DEC_ACTIVE_LOW_EN
  assign bus.d = ~d_q;
`else
  assign bus.d = d_q;
`endif
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule
